drop_scheduler: RTL and testbench
=================================

// Module: drop_scheduler
// PURPOSE
//  Gravity/lock sequencer for the Tetris game core. Generates piece-drop requests at a
//  level-dependent period, with a faster period during soft drop. When a piece lands,
//  it runs a lock-delay window and then issues one lock pulse. Provides pause, and waits
//  for the next spawn. Sits between the game-control FSM and the board/piece-move logic.
// PARAMETERS
//  CNT_W        31          width of period/lock counters
//  BASE_PERIOD  45_000_000  clk cycles per drop at level 0
//  LEVEL_STEP   3_000_000   cycles removed from period per level
//  MIN_PERIOD   5_000_000   floor on level-derived period
//  SOFT_PERIOD  2_500_000   period while soft_drop=1 (not floored)
//  LOCK_DELAY   25_000_000  cycles a landed piece rests before lock
// PORTS
//  clk_50M     in   1      system clock, 50 MHz
//  rst         in   1      async reset, active-high
//  run         in   1      game running; 0 forces IDLE
//  pause       in   1      level: hold scheduling while 1
//  level       in   5      game level 0..31
//  soft_drop   in   1      level: use SOFT_PERIOD
//  landed      in   1      level: active piece cannot move down
//  drop_ack    in   1      move logic consumed drop_req
//  new_piece   in   1      pulse: next piece spawned
//  drop_req    out  1      drop request, held until drop_ack
//  lock_req    out  1      one-cycle pulse: lock piece into board
//  state       out  3      IDLE=0 FALL=1 LOCK=2 SPAWN=3 PAUSED=4
//  drop_period out  CNT_W  currently selected period (registered)
// BEHAVIOUR
//  - Reset: state=IDLE; drop_req=0, lock_req=0; both counters=0; drop_period=BASE_PERIOD.
//  - Priority each cycle: rst > run=0 > per-state rules. The run=0 condition clears the counters
//    and drop_req, and sets state to IDLE on the next edge, from any state.
//  - drop_period is registered every cycle. If soft_drop=1, it is SOFT_PERIOD. Otherwise it is
//    max(BASE_PERIOD - level*LEVEL_STEP, MIN_PERIOD). Compute this in CNT_W+6 bits signed, so an
//    underflow clamps to MIN_PERIOD. Output latency is 1 cycle.
//  - IDLE: if run=1, go to FALL with cnt=0.
//  - FALL, drop_req=0:
//    - If landed=1, go to LOCK with lock_cnt=0.
//    - Otherwise, if pause=1, go to PAUSED.
//    - Otherwise, if cnt >= drop_period-1, set drop_req<=1 and cnt<=0.
//    - Otherwise, cnt++.
//    - The >= compare means a period shortened mid-count fires on the next cycle.
//  - FALL, drop_req=1:
//    - cnt is frozen. On drop_ack=1, set drop_req<=0.
//    - landed and pause are deferred until the request is acked.
//    - drop_ack while drop_req=0 is ignored.
//  - LOCK:
//    - If landed=0 (piece slid off), go to FALL with cnt=0.
//    - Otherwise, if pause=1, go to PAUSED; lock_cnt is held.
//    - Otherwise, if lock_cnt == LOCK_DELAY-1, pulse lock_req for 1 cycle and go to SPAWN.
//    - Otherwise, lock_cnt++.
//  - SPAWN: counters are idle. If new_piece=1, go to FALL with cnt=0. A new_piece in any other
//    state is ignored.
//  - PAUSED: cnt and lock_cnt are frozen and outputs are held low. Record the return state
//    (FALL/LOCK) on entry. When pause=0, return to it on the next edge and resume the counts
//    without reloading. If pause is asserted in SPAWN, the block remains in SPAWN.
//  - Simultaneous drop_ack and landed in FALL: drop_req clears this edge, and landed is
//    evaluated the next cycle.
//  - lock_req is never asserted together with drop_req.
// TESTING
//  (small params: BASE=20, STEP=2, MIN=4, SOFT=3, LOCK=5, CNT_W=8)
//  1 rst pulse mid-FALL -> state=0, drop_req=0, lock_req=0 immediately (async).
//  2 run=1, level=0, ack 1 cycle after each req -> drop_req rises 20 cycles after FALL entry,
//    then every 21 cycles (req+ack cycle).
//  3 level=5 -> period 10; level=10 -> period 4 (clamped); soft_drop=1 -> period 3; no ack ->
//    drop_req stays high and cnt stays frozen.
//  4 landed=1 held in FALL -> LOCK; lock_req is a single pulse 5 cycles later; state=SPAWN;
//    new_piece -> FALL.
//  5 landed drops to 0 after 2 LOCK cycles -> FALL with cnt=0, and no lock_req.
//  6 pause 7 cycles mid-FALL at cnt=8 -> state=4 throughout; resumes and fires drop_req
//    12 cycles later. run=0 in PAUSED -> IDLE.

Source files
------------

// File: rtl/drop_scheduler.sv
// Gravity/lock sequencer: paces drop requests by level (or soft drop), runs the
// lock-delay window after landing, pulses lock_req, then waits for the next spawn.
module drop_scheduler #(
  parameter int CNT_W       = 31,
  parameter int BASE_PERIOD = 45_000_000,
  parameter int LEVEL_STEP  = 3_000_000,
  parameter int MIN_PERIOD  = 5_000_000,
  parameter int SOFT_PERIOD = 2_500_000,
  parameter int LOCK_DELAY  = 25_000_000
) (
  input  logic             clk_50M,
  input  logic             rst,
  input  logic             run,
  input  logic             pause,
  input  logic [4:0]       level,
  input  logic             soft_drop,
  input  logic             landed,
  input  logic             drop_ack,
  input  logic             new_piece,
  output logic             drop_req,
  output logic             lock_req,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] drop_period
);
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FALL   = 3'd1;
  localparam logic [2:0] ST_LOCK   = 3'd2;
  localparam logic [2:0] ST_SPAWN  = 3'd3;
  localparam logic [2:0] ST_PAUSED = 3'd4;
  localparam int PW = CNT_W + 6;

  logic [2:0]       state_q, state_d, ret_q, ret_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, lock_cnt_q, lock_cnt_d, period_q, period_d;
  logic             drop_req_q, drop_req_d, lock_req_q, lock_req_d;

  // Signed headroom lets a large level drive the raw period negative and clamp.
  logic [PW-1:0]        lvl_cost;
  logic signed [PW-1:0] per_raw;
  always_comb begin
    lvl_cost = PW'(level) * PW'(LEVEL_STEP);
    per_raw  = signed'(PW'(BASE_PERIOD)) - signed'(lvl_cost);
    if (soft_drop)
      period_d = CNT_W'(SOFT_PERIOD);
    else if (per_raw < signed'(PW'(MIN_PERIOD)))
      period_d = CNT_W'(MIN_PERIOD);
    else
      period_d = per_raw[CNT_W-1:0];
  end

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    cnt_d      = cnt_q;
    lock_cnt_d = lock_cnt_q;
    drop_req_d = drop_req_q;
    lock_req_d = 1'b0;
    if (!run) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      lock_cnt_d = '0;
      drop_req_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_FALL;
          cnt_d   = '0;
        end
        ST_FALL: begin
          // An outstanding request defers landed/pause until it is consumed.
          if (drop_req_q) begin
            if (drop_ack) drop_req_d = 1'b0;
          end else if (landed) begin
            state_d    = ST_LOCK;
            lock_cnt_d = '0;
          end else if (pause) begin
            state_d = ST_PAUSED;
            ret_d   = ST_FALL;
          end else if (cnt_q >= period_q - CNT_W'(1)) begin
            drop_req_d = 1'b1;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_LOCK: begin
          if (!landed) begin
            state_d = ST_FALL;
            cnt_d   = '0;
          end else if (pause) begin
            state_d = ST_PAUSED;
            ret_d   = ST_LOCK;
          end else if (lock_cnt_q == CNT_W'(LOCK_DELAY - 1)) begin
            lock_req_d = 1'b1;
            state_d    = ST_SPAWN;
          end else begin
            lock_cnt_d = lock_cnt_q + CNT_W'(1);
          end
        end
        ST_SPAWN: begin
          if (new_piece) begin
            state_d = ST_FALL;
            cnt_d   = '0;
          end
        end
        ST_PAUSED: begin
          if (!pause) state_d = ret_q;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ret_q      <= ST_FALL;
      cnt_q      <= '0;
      lock_cnt_q <= '0;
      drop_req_q <= 1'b0;
      lock_req_q <= 1'b0;
      period_q   <= CNT_W'(BASE_PERIOD);
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      cnt_q      <= cnt_d;
      lock_cnt_q <= lock_cnt_d;
      drop_req_q <= drop_req_d;
      lock_req_q <= lock_req_d;
      period_q   <= period_d;
    end
  end

  assign drop_req    = drop_req_q;
  assign lock_req    = lock_req_q;
  assign state       = state_q;
  assign drop_period = period_q;
endmodule

// File: tb/tb_drop_scheduler.sv
// Directed bench for drop_scheduler with small periods; expected values hand-derived.
module tb_drop_scheduler;
  localparam int CNT_W = 8;

  logic             clk_50M = 1'b0;
  logic             rst, run, pause, soft_drop, landed, drop_ack, new_piece;
  logic [4:0]       level;
  logic             drop_req, lock_req;
  logic [2:0]       state;
  logic [CNT_W-1:0] drop_period;

  int checks = 0;
  int failures = 0;
  int n;

  drop_scheduler #(
    .CNT_W(CNT_W), .BASE_PERIOD(20), .LEVEL_STEP(2), .MIN_PERIOD(4),
    .SOFT_PERIOD(3), .LOCK_DELAY(5)
  ) dut (
    .clk_50M(clk_50M), .rst(rst), .run(run), .pause(pause), .level(level),
    .soft_drop(soft_drop), .landed(landed), .drop_ack(drop_ack),
    .new_piece(new_piece), .drop_req(drop_req), .lock_req(lock_req),
    .state(state), .drop_period(drop_period)
  );

  always #5 clk_50M = ~clk_50M;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_50M);
    #1;
  endtask

  task automatic wait_req(output int cnt);
    cnt = 0;
    while (!drop_req && cnt < 200) begin cyc(); cnt++; end
  endtask

  task automatic wait_lock(output int cnt);
    cnt = 0;
    while (!lock_req && cnt < 200) begin cyc(); cnt++; end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; pause = 1'b0; soft_drop = 1'b0; landed = 1'b0;
    drop_ack = 1'b0; new_piece = 1'b0; level = 5'd0;
    cyc(); cyc();
    chk("rst_state", 32'(state), 0);
    chk("rst_drop_req", 32'(drop_req), 0);
    chk("rst_lock_req", 32'(lock_req), 0);
    chk("rst_period", 32'(drop_period), 20);

    // Level 0 pacing: first request 20 cycles after FALL entry, then every 21.
    rst = 1'b0; run = 1'b1;
    cyc();
    chk("idle_to_fall", 32'(state), 1);
    wait_req(n);
    chk("first_req_lat", 32'(n), 20);
    for (int k = 0; k < 2; k++) begin
      drop_ack = 1'b1;
      cyc();
      drop_ack = 1'b0;
      chk("ack_clears", 32'(drop_req), 0);
      wait_req(n);
      chk("req_spacing", 32'(n + 1), 21);
    end

    // Async reset while a request is pending.
    #2 rst = 1'b1;
    #1;
    chk("async_state", 32'(state), 0);
    chk("async_drop_req", 32'(drop_req), 0);
    chk("async_period", 32'(drop_period), 20);

    level = 5'd5;
    cyc();
    rst = 1'b0;
    cyc();
    chk("lvl5_period", 32'(drop_period), 10);
    wait_req(n);
    chk("lvl5_req_lat", 32'(n), 10);
    repeat (5) cyc();
    chk("no_ack_held", 32'(drop_req), 1);
    chk("no_ack_state", 32'(state), 1);
    level = 5'd10;
    cyc();
    chk("lvl10_clamp", 32'(drop_period), 4);
    level = 5'd31;
    cyc();
    chk("lvl31_clamp", 32'(drop_period), 4);
    soft_drop = 1'b1;
    cyc();
    chk("soft_period", 32'(drop_period), 3);
    drop_ack = 1'b1;
    cyc();
    drop_ack = 1'b0;
    wait_req(n);
    chk("soft_req_lat", 32'(n), 3);

    // Period shortened mid-count fires on the following cycle.
    soft_drop = 1'b0; level = 5'd0;
    cyc();
    drop_ack = 1'b1;
    cyc();
    drop_ack = 1'b0;
    chk("period_back", 32'(drop_period), 20);
    repeat (10) cyc();
    soft_drop = 1'b1;
    wait_req(n);
    chk("shorten_fire", 32'(n), 2);
    soft_drop = 1'b0;
    cyc();

    // Ack and landed together: ack first, landed seen next cycle.
    drop_ack = 1'b1; landed = 1'b1;
    cyc();
    drop_ack = 1'b0;
    chk("ack_land_req", 32'(drop_req), 0);
    chk("ack_land_state", 32'(state), 1);
    cyc();
    chk("lock_entry", 32'(state), 2);
    wait_lock(n);
    chk("lock_lat", 32'(n), 5);
    chk("lock_to_spawn", 32'(state), 3);
    chk("lock_no_drop", 32'(drop_req), 0);
    pause = 1'b1;
    cyc();
    chk("lock_pulse_1cy", 32'(lock_req), 0);
    chk("pause_in_spawn", 32'(state), 3);
    pause = 1'b0; new_piece = 1'b1;
    cyc();
    new_piece = 1'b0;
    chk("spawn_to_fall", 32'(state), 1);

    // Slide off after two LOCK cycles.
    cyc();
    chk("relock", 32'(state), 2);
    cyc();
    landed = 1'b0;
    cyc();
    chk("slide_off_state", 32'(state), 1);
    chk("slide_off_nolock", 32'(lock_req), 0);
    wait_req(n);
    chk("slide_cnt_reset", 32'(n), 20);
    drop_ack = 1'b1;
    cyc();
    drop_ack = 1'b0;

    // Pause at cnt=8 for 7 cycles, then resume the count.
    repeat (8) cyc();
    pause = 1'b1;
    for (int k = 0; k < 7; k++) begin
      cyc();
      chk("paused_state", 32'(state), 4);
    end
    chk("paused_no_req", 32'(drop_req), 0);
    pause = 1'b0;
    cyc();
    chk("resume_fall", 32'(state), 1);
    wait_req(n);
    chk("resume_req_lat", 32'(n), 12);

    drop_ack = 1'b1;
    cyc();
    drop_ack = 1'b0; pause = 1'b1;
    cyc();
    chk("pause_again", 32'(state), 4);
    run = 1'b0;
    cyc();
    chk("run0_idle", 32'(state), 0);
    chk("run0_req", 32'(drop_req), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
